// File: rtl/fft_frame_feeder.sv
// Ping-pong frame packer feeding the FFT core's Avalon-ST sink: continuous I/Q
// samples are gathered into N-point banks and streamed out with sop/eop framing.
module fft_frame_feeder #(
  parameter int N          = 128,
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_real,
  input  logic [DATA_WIDTH-1:0] in_imag,
  input  logic                  inverse_cfg,
  input  logic                  clear_stats,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [DATA_WIDTH-1:0] out_real,
  output logic [DATA_WIDTH-1:0] out_imag,
  output logic [1:0]            out_error,
  output logic                  out_inverse,
  output logic                  overflow,
  output logic [15:0]           drop_count
);

  localparam int MW = 2 * DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREFETCH = 2'd1,
    STREAM   = 2'd2
  } rd_state_t;

  logic [MW-1:0]         mem_r [0:2*N-1];
  logic [MW-1:0]         rd_q_r;

  logic                  wr_bank_r;
  logic [ADDR_WIDTH-1:0] wr_addr_r;
  logic [1:0]            full_r;
  logic [1:0]            full_next_s;
  logic [1:0]            inv_r;
  logic                  accept_s;
  logic                  drop_s;
  logic                  wr_last_s;

  rd_state_t             state_r;
  rd_state_t             state_next_s;
  logic                  rd_bank_r;
  logic [ADDR_WIDTH-1:0] rd_idx_r;
  logic                  hs_s;
  logic                  load_first_s;
  logic                  adv_s;
  logic                  eop_hs_s;
  logic                  raddr_bank_s;
  logic [ADDR_WIDTH-1:0] raddr_s;

  assign accept_s  = in_valid && !full_r[wr_bank_r];
  assign drop_s    = in_valid && full_r[wr_bank_r];
  assign wr_last_s = (wr_addr_r == LAST_ADDR);
  assign hs_s      = out_valid && out_ready;
  assign out_error = 2'b00;

  // Full flags: fill sets the write bank, eop handshake clears the read bank
  always_comb begin
    full_next_s = full_r;
    for (int b = 0; b < 2; b++) begin
      if (accept_s && wr_last_s && (wr_bank_r == 1'(b))) begin
        full_next_s[b] = 1'b1;
      end else if (eop_hs_s && (rd_bank_r == 1'(b))) begin
        full_next_s[b] = 1'b0;
      end else begin
        full_next_s[b] = full_r[b];
      end
    end
  end

  // Write-side bookkeeping: address, bank select, full and inverse flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_bank_r <= 1'b0;
      wr_addr_r <= '0;
      full_r    <= 2'b00;
      inv_r     <= 2'b00;
    end else begin
      full_r <= full_next_s;
      if (accept_s) begin
        if (wr_addr_r == '0) begin
          inv_r[wr_bank_r] <= inverse_cfg;
        end
        if (wr_last_s) begin
          wr_bank_r <= ~wr_bank_r;
          wr_addr_r <= '0;
        end else begin
          wr_addr_r <= wr_addr_r + ADDR_WIDTH'(1);
        end
      end
    end
  end

  // Sample storage with registered read; contents need no reset
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_r[{wr_bank_r, wr_addr_r}] <= {in_real, in_imag};
    end
    rd_q_r <= mem_r[{raddr_bank_s, raddr_s}];
  end

  // Drop pulse and saturating drop counter; clear wins over increment
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow   <= 1'b0;
      drop_count <= 16'h0000;
    end else begin
      overflow <= drop_s;
      if (clear_stats) begin
        drop_count <= 16'h0000;
      end else if (drop_s && (drop_count != 16'hFFFF)) begin
        drop_count <= drop_count + 16'h0001;
      end
    end
  end

  // Read FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Read FSM next state and read address; rd_q_r always holds the sample after
  // the one presented, so a handshake can advance without a bubble
  always_comb begin
    state_next_s = state_r;
    raddr_bank_s = rd_bank_r;
    raddr_s      = '0;
    load_first_s = 1'b0;
    adv_s        = 1'b0;
    eop_hs_s     = 1'b0;
    case (state_r)
      IDLE: begin
        raddr_s = '0;
        if (full_r[rd_bank_r]) begin
          state_next_s = PREFETCH;
        end else begin
          state_next_s = IDLE;
        end
      end
      PREFETCH: begin
        raddr_s      = ADDR_WIDTH'(1);
        load_first_s = 1'b1;
        state_next_s = STREAM;
      end
      STREAM: begin
        if (hs_s && (rd_idx_r == LAST_ADDR)) begin
          eop_hs_s     = 1'b1;
          raddr_bank_s = ~rd_bank_r;
          raddr_s      = '0;
          if (full_r[~rd_bank_r]) begin
            state_next_s = PREFETCH;
          end else begin
            state_next_s = IDLE;
          end
        end else if (hs_s) begin
          adv_s   = 1'b1;
          raddr_s = rd_idx_r + ADDR_WIDTH'(2);
        end else begin
          raddr_s = rd_idx_r + ADDR_WIDTH'(1);
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Output register: load sample 0, advance on handshake, retire on eop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_bank_r   <= 1'b0;
      rd_idx_r    <= '0;
      out_valid   <= 1'b0;
      out_sop     <= 1'b0;
      out_eop     <= 1'b0;
      out_real    <= '0;
      out_imag    <= '0;
      out_inverse <= 1'b0;
    end else if (load_first_s) begin
      rd_idx_r    <= '0;
      out_valid   <= 1'b1;
      out_sop     <= 1'b1;
      out_eop     <= 1'b0;
      out_real    <= rd_q_r[MW-1:DATA_WIDTH];
      out_imag    <= rd_q_r[DATA_WIDTH-1:0];
      out_inverse <= inv_r[rd_bank_r];
    end else if (eop_hs_s) begin
      rd_bank_r   <= ~rd_bank_r;
      rd_idx_r    <= '0;
      out_valid   <= 1'b0;
      out_sop     <= 1'b0;
      out_eop     <= 1'b0;
      out_real    <= '0;
      out_imag    <= '0;
      out_inverse <= 1'b0;
    end else if (adv_s) begin
      rd_idx_r <= rd_idx_r + ADDR_WIDTH'(1);
      out_sop  <= 1'b0;
      out_eop  <= ((rd_idx_r + ADDR_WIDTH'(1)) == LAST_ADDR);
      out_real <= rd_q_r[MW-1:DATA_WIDTH];
      out_imag <= rd_q_r[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Scoreboard bench for fft_frame_feeder: expected samples are queued as they are
// driven and compared at every output handshake.
module tb_fft_frame_feeder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [11:0] in_real;
  logic [11:0] in_imag;
  logic        inverse_cfg;
  logic        clear_stats;
  logic        out_valid;
  logic        out_ready;
  logic        out_sop;
  logic        out_eop;
  logic [11:0] out_real;
  logic [11:0] out_imag;
  logic [1:0]  out_error;
  logic        out_inverse;
  logic        overflow;
  logic [15:0] drop_count;

  typedef struct packed {
    logic [11:0] re;
    logic [11:0] im;
    logic        sop;
    logic        eop;
    logic        inv;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          ovf_cnt  = 0;
  logic        prev_stall = 1'b0;
  logic [28:0] prev_vec;

  fft_frame_feeder #(.N(128), .ADDR_WIDTH(7), .DATA_WIDTH(12)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_real(in_real),
    .in_imag(in_imag), .inverse_cfg(inverse_cfg), .clear_stats(clear_stats),
    .out_valid(out_valid), .out_ready(out_ready), .out_sop(out_sop),
    .out_eop(out_eop), .out_real(out_real), .out_imag(out_imag),
    .out_error(out_error), .out_inverse(out_inverse), .overflow(overflow),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  // Scoreboard: compare each handshake, check stall stability, count overflow pulses
  always @(negedge clk) begin
    logic [28:0] got;
    exp_t e;
    got = {out_real, out_imag, out_sop, out_eop, out_inverse, out_error};
    if (reset_n) begin
      if (prev_stall) begin
        n_checks++;
        if (got !== prev_vec) $display("FAIL stall_stable: got %h required %h", got, prev_vec);
        else n_pass++;
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_output: got %h with empty scoreboard", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== {e.re, e.im, e.sop, e.eop, e.inv, 2'b00})
            $display("FAIL sample: got %h required %h", got, {e.re, e.im, e.sop, e.eop, e.inv, 2'b00});
          else n_pass++;
        end
      end
      if (overflow) ovf_cnt++;
      prev_stall = out_valid && !out_ready;
      prev_vec   = got;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic push_exp(input int v, input int k, input logic inv);
    exp_t e;
    e.re  = 12'(v);
    e.im  = 12'(-v);
    e.sop = ((k % 128) == 0);
    e.eop = ((k % 128) == 127);
    e.inv = inv;
    exp_q.push_back(e);
  endtask

  task automatic drive_sample(input int v);
    in_valid = 1'b1;
    in_real  = 12'(v);
    in_imag  = 12'(-v);
  endtask

  task automatic test_reset();
    int vseen;
    reset_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid = 1'($urandom); in_real = 12'($urandom); in_imag = 12'($urandom);
      inverse_cfg = 1'($urandom); out_ready = 1'($urandom); clear_stats = 1'($urandom);
      n_checks++;
      if ({out_valid, out_sop, out_eop, out_real, out_imag, out_error, out_inverse, overflow, drop_count} !== 47'd0)
        $display("FAIL reset_outputs: got %h required 0",
                 {out_valid, out_sop, out_eop, out_real, out_imag, out_error, out_inverse, overflow, drop_count});
      else n_pass++;
    end
    in_valid = 1'b0; inverse_cfg = 1'b0; clear_stats = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    vseen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid) vseen++;
    end
    n_checks++;
    if (vseen != 0) $display("FAIL idle_after_reset: got %0d valid cycles required 0", vseen);
    else n_pass++;
  endtask

  task automatic test_single_frame();
    int early, lat, gaps, t;
    out_ready = 1'b1;
    early = 0;
    for (int k = 0; k < 128; k++) begin
      @(posedge clk); #1;
      if (out_valid) early++;
      drive_sample(k);
      push_exp(k, k, 1'b0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (early != 0) $display("FAIL valid_before_full: got %0d required 0", early);
    else n_pass++;
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if (lat > 3) $display("FAIL first_valid_latency: got %0d required <=3", lat);
    else n_pass++;
    gaps = 0;
    for (int i = 0; i < 128; i++) begin
      if (!out_valid) gaps++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (gaps != 0) $display("FAIL frame_contiguous: got %0d bubbles required 0", gaps);
    else n_pass++;
    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL single_drain: got %0d left required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int k, c;
    k = 0; c = 0; ovf_cnt = 0;
    while ((k < 256 || exp_q.size() != 0) && c < 3000) begin
      @(posedge clk); #1;
      if (k < 256) begin
        drive_sample(k + 1000);
        push_exp(k + 1000, k, 1'b0);
        k++;
      end else begin
        in_valid = 1'b0;
      end
      out_ready = ((c % 4) == 0) || ((c % 4) == 3);
      c++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL bp_drain: got %0d left required 0", exp_q.size());
    else n_pass++;
    n_checks++;
    if (drop_count !== 16'd0 || ovf_cnt != 0)
      $display("FAIL bp_no_drop: got drop_count %0d pulses %0d required 0", drop_count, ovf_cnt);
    else n_pass++;
  endtask

  task automatic test_inverse();
    int t;
    out_ready = 1'b1;
    for (int k = 0; k < 256; k++) begin
      @(posedge clk); #1;
      inverse_cfg = (k < 60) ? 1'b1 : (k < 90) ? 1'b0 : (k < 128) ? 1'b1 : 1'b0;
      drive_sample(k + 1500);
      push_exp(k + 1500, k, (k < 128));
    end
    @(posedge clk); #1;
    in_valid = 1'b0; inverse_cfg = 1'b0;
    t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      @(posedge clk); #1;
      t++;
    end
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL inverse_drain: got %0d left required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_overflow();
    int t;
    ovf_cnt = 0;
    out_ready = 1'b0;
    for (int k = 0; k < 384; k++) begin
      @(posedge clk); #1;
      drive_sample(k);
      if (k < 256) push_exp(k, k, 1'b0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (drop_count !== 16'd128) $display("FAIL drop_count_128: got %0d required 128", drop_count);
    else n_pass++;
    in_valid = 1'b1; clear_stats = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; clear_stats = 1'b0;
    n_checks++;
    if (drop_count !== 16'd0) $display("FAIL clear_priority: got %0d required 0", drop_count);
    else n_pass++;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (drop_count !== 16'd1) $display("FAIL drop_after_clear: got %0d required 1", drop_count);
    else n_pass++;
    clear_stats = 1'b1;
    @(posedge clk); #1;
    clear_stats = 1'b0;
    n_checks++;
    if (drop_count !== 16'd0) $display("FAIL clear_stats: got %0d required 0", drop_count);
    else n_pass++;
    n_checks++;
    if (ovf_cnt != 130) $display("FAIL overflow_pulses: got %0d required 130", ovf_cnt);
    else n_pass++;
    out_ready = 1'b1;
    t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      @(posedge clk); #1;
      t++;
    end
    repeat (10) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL overflow_drain: got %0d left required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_mid_frame_reset();
    int t;
    out_ready = 1'b1;
    for (int k = 0; k < 128; k++) begin
      @(posedge clk); #1;
      drive_sample(k + 300);
      push_exp(k + 300, k, 1'b0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    t = 0;
    while (exp_q.size() > 78 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    n_checks++;
    if (!out_valid || out_real !== 12'd350)
      $display("FAIL at_index_50: got valid %b real %0d required 1 350", out_valid, out_real);
    else n_pass++;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, out_sop, out_eop, out_real, out_imag, out_inverse, overflow, drop_count} !== 45'd0)
      $display("FAIL reset_mid_frame: got %h required 0",
               {out_valid, out_sop, out_eop, out_real, out_imag, out_inverse, overflow, drop_count});
    else n_pass++;
    exp_q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int k = 0; k < 128; k++) begin
      @(posedge clk); #1;
      drive_sample(k + 500);
      push_exp(k + 500, k, 1'b0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL fresh_frame_drain: got %0d left required 0", exp_q.size());
    else n_pass++;
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_real = 12'd0; in_imag = 12'd0;
    inverse_cfg = 1'b0; clear_stats = 1'b0; out_ready = 1'b0;
    test_reset();
    test_single_frame();
    test_backpressure();
    test_inverse();
    test_overflow();
    test_mid_frame_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
